if_fetch: RTL and testbench
===========================

# if_fetch

Instruction-fetch stage of the RV32I pipeline, directly upstream of the decode stage. It holds the PC, fetches each 32-bit instruction as four byte reads through the shared byte-wide memory controller, and assembles them little-endian. It presents `pc_o`/`inst_o`/`valid_o` to the IF/ID latch, holds them while the pipeline is stalled, and redirects the PC on taken branches or jumps from EX.

## Interface
Parameters:
- `RESET_PC`, 32'h0, PC value after reset.
- `ICACHE_LINES`, 64, number of icache lines; power of two. Used only with `ICACHE_EN`.

Ports:
- `clk`  in  1  Clock.
- `rst`  in  1  Reset, synchronous, active-low. `rst`==0 at a rising edge resets the block.
- `stall_i`  in  1  Downstream cannot accept; hold the output.
- `branch_i`  in  1  One-cycle redirect pulse from EX.
- `branch_target_i`  in  32  Redirect PC.
- `mem_req_o`  out  1  Byte read request.
- `mem_addr_o`  out  32  Byte address of the request.
- `mem_gnt_i`  in  1  Controller accepted the request this cycle.
- `mem_rvalid_i`  in  1  Returned byte valid.
- `mem_rdata_i`  in  8  Returned byte.
- `pc_o`  out  32  PC of the presented instruction.
- `inst_o`  out  32  Presented instruction.
- `valid_o`  out  1  `pc_o`/`inst_o` are valid.

## Operation
- **States:** `S_REQ` (issue and collect bytes) and `S_OUT` (word presented).
- **Byte issue (S_REQ):**
  - `mem_req_o`=1 and `mem_addr_o`=`pc`+`issue_cnt` while `issue_cnt`<4.
  - `issue_cnt` increments on `mem_gnt_i`.
  - Without a grant, `mem_req_o` and `mem_addr_o` stay stable.
- **Byte return:** data arrives exactly one cycle after its grant.
  - On `mem_rvalid_i`, write `inst_buf[8*recv_cnt +: 8]` and increment `recv_cnt`.
  - When the 4th byte arrives, register `inst_o` = assembled word, `pc_o`=`pc`, set `valid_o`=1, and go to `S_OUT`.
- **Output hold (S_OUT):** `mem_req_o`=0.
  - A clock edge with `valid_o`=1 and `stall_i`=0 consumes the word.
  - On consume: `valid_o`←0, `pc`←`pc`+4 (mod 2^32), counters←0, go to `S_REQ`.
- **Redirect (`branch_i`=1):**
  - Combinationally forces `mem_req_o`=0.
  - Any `mem_rvalid_i` in that cycle is ignored. At most one byte can be in flight, so nothing stale arrives afterwards.
  - Next edge: `pc`←`branch_target_i`, counters←0, `valid_o`←0, state←`S_REQ`.
  - Branch has priority over stall and over consume.
  - `branch_target_i[1:0]` is not checked; the target is fetched as given.
- **Reset:** `pc`=`RESET_PC`, `pc_o`=0, `inst_o`=0, `valid_o`=0, `mem_req_o`=0, `mem_addr_o`=0, counters=0, state=`S_REQ`.
  - Reset mid-fetch abandons the fetch. A byte returned in the cycle after reset is ignored.

## Timing
- Zero-wait memory, no stall: grants in cycles 0–3, data in cycles 1–4, `valid_o` high in cycle 5, next request in cycle 6. One instruction per 6 cycles.
- Each cycle with `mem_gnt_i`=0 adds one cycle.
- `valid_o` low means the decode stage sees `inst_o`=0, which decodes as an invalid instruction, i.e. a bubble.

## Configuration
- `ICACHE_EN` defined: direct-mapped, one word per line.
  - Index = `pc[2+:log2(ICACHE_LINES)]`; tag = remaining upper PC bits; valid bit per line.
  - Lookup happens in `S_REQ` with `issue_cnt`==0. On a hit, no memory request is made and the output is registered that cycle (`valid_o` one cycle later).
  - On a miss, fetch from memory as normal and fill the line when the word completes.
  - Reset clears all valid bits. Redirects do not invalidate lines; self-modifying code is unsupported.
- `ICACHE_EN` undefined: no cache storage; every fetch goes to memory; `ICACHE_LINES` is ignored.

## Structure
- Shared defines file: `InstAddrBus`, `InstBus`, state encodings `S_REQ`/`S_OUT`, default `ICACHE_LINES`.
- Active-low reset constant: add `RstnEnable`=1'b0. The existing active-high `RstEnable` is not reused.
- Sub-module: `icache` (lookup and fill ports), instantiated only under `ICACHE_EN`.

## Test plan
- Reset then zero-wait memory holding 32'h00500093 at 0x0 → bytes requested from addresses 0,1,2,3; `inst_o`=32'h00500093, `pc_o`=0, `valid_o`=1 in cycle 5.
- `mem_gnt_i` low for 3 cycles on byte 2 → `mem_addr_o`=2 stays stable; `valid_o` is delayed by 3 cycles; word is correct.
- `stall_i` high for 4 cycles while `valid_o`=1 → outputs are unchanged and `mem_req_o`=0; after release, the next request is for address 4.
- `branch_i` with target 0x100 in the cycle byte 1 returns → that byte is dropped; next requests are 0x100..0x103; `pc_o`=0x100.
- `rst` driven low during byte 2 → the cycle after, every output is at its reset value; fetch restarts at `RESET_PC`.
- `ICACHE_EN`: loop 0x0→0x4→branch to 0x0 → second fetch of 0x0 issues no memory request, and `valid_o` rises one cycle after the lookup.

Source files
------------

// File: rtl/if_fetch_pkg.sv
// Shared bus widths, FSM states and reset level for the fetch stage.
// Default for ICACHE_LINES lives here; the cache itself is gated by ICACHE_EN.
package if_fetch_pkg;

  localparam int InstAddrBus    = 32;
  localparam int InstBus        = 32;
  localparam int IcacheLinesDef = 64;

  localparam logic RstnEnable = 1'b0;

  typedef logic [InstAddrBus-1:0] inst_addr_t;
  typedef logic [InstBus-1:0]     inst_t;

  typedef enum logic {
    S_REQ = 1'b0,
    S_OUT = 1'b1
  } state_e;

endpackage

// File: rtl/if_fetch_if.sv
// Byte-wide read port between the fetch stage and the memory controller.
// master = fetch side, slave = controller side.
interface if_fetch_if;
  import if_fetch_pkg::*;

  logic       mem_req_o;
  inst_addr_t mem_addr_o;
  logic       mem_gnt_i;
  logic       mem_rvalid_i;
  logic [7:0] mem_rdata_i;

  modport master (
    output mem_req_o,
    output mem_addr_o,
    input  mem_gnt_i,
    input  mem_rvalid_i,
    input  mem_rdata_i
  );

  modport slave (
    input  mem_req_o,
    input  mem_addr_o,
    output mem_gnt_i,
    output mem_rvalid_i,
    output mem_rdata_i
  );

endinterface

// File: rtl/if_fetch_icache.sv
// Direct-mapped one-word-per-line icache, addressed by word address.
// Instantiated by if_fetch only when ICACHE_EN is defined.
module if_fetch_icache
  import if_fetch_pkg::*;
#(
  parameter int LINES = IcacheLinesDef
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [29:0] lookup_wa_i,
  output logic        hit_o,
  output inst_t       hit_data_o,
  input  logic        fill_i,
  input  logic [29:0] fill_wa_i,
  input  inst_t       fill_data_i
);

  localparam int IdxW = $clog2(LINES);
  localparam int TagW = 30 - IdxW;

  logic [LINES-1:0] valid_q;
  logic [TagW-1:0]  tag_q  [LINES];
  inst_t            data_q [LINES];

  logic [IdxW-1:0] l_idx;
  logic [IdxW-1:0] f_idx;

  assign l_idx = lookup_wa_i[IdxW-1:0];
  assign f_idx = fill_wa_i[IdxW-1:0];

  assign hit_o = valid_q[l_idx] &&
                 tag_q[l_idx] == lookup_wa_i[29 -: TagW];
  assign hit_data_o = data_q[l_idx];

  always_ff @(posedge clk) begin
    if (rst == RstnEnable) begin
      valid_q <= '0;
    end else if (fill_i) begin
      valid_q[f_idx] <= 1'b1;
    end
  end

  // Tag/data need no reset: the valid bit guards them.
  always_ff @(posedge clk) begin
    if (fill_i) begin
      tag_q[f_idx]  <= fill_wa_i[29 -: TagW];
      data_q[f_idx] <= fill_data_i;
    end
  end

endmodule

// File: rtl/if_fetch.sv
// RV32I fetch stage: four byte reads per instruction, little-endian.
// Define ICACHE_EN to add a direct-mapped icache in front of memory.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter inst_addr_t RESET_PC     = 32'h0,
  parameter int         ICACHE_LINES = IcacheLinesDef
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       stall_i,
  input  logic       branch_i,
  input  inst_addr_t branch_target_i,
  if_fetch_if.master mem,
  output inst_addr_t pc_o,
  output inst_t      inst_o,
  output logic       valid_o
);

  state_e     state_q;
  inst_addr_t pc_q;
  inst_addr_t addr_q;
  inst_addr_t pc_o_q;
  inst_t      inst_q;
  logic [2:0] issue_q;
  logic [2:0] issue_d;
  logic [1:0] recv_q;
  logic [23:0] buf_q;
  logic       req_q;
  logic       inflight_q;
  logic       valid_q;

  logic  gnt;
  logic  rv;
  logic  last;
  logic  hit;
  inst_t hit_data;
  inst_t word;

  if ((ICACHE_LINES & (ICACHE_LINES - 1)) != 0) begin : g_lines_chk
    $error("ICACHE_LINES must be a power of two");
  end

  assign mem.mem_req_o  = req_q & ~branch_i & ~hit;
  assign mem.mem_addr_o = addr_q;

  // A return only counts if it answers last cycle's grant.
  assign gnt     = mem.mem_req_o & mem.mem_gnt_i;
  assign rv      = mem.mem_rvalid_i & inflight_q;
  assign last    = rv && recv_q == 2'd3;
  assign word    = {mem.mem_rdata_i, buf_q};
  assign issue_d = issue_q + {2'b00, gnt};

`ifdef ICACHE_EN
  logic c_hit;
  logic fill;

  assign fill = state_q == S_REQ && !branch_i && last;
  assign hit  = c_hit && state_q == S_REQ &&
                issue_q == 3'd0;

  if_fetch_icache #(
    .LINES(ICACHE_LINES)
  ) u_icache (
    .clk        (clk),
    .rst        (rst),
    .lookup_wa_i(pc_q[31:2]),
    .hit_o      (c_hit),
    .hit_data_o (hit_data),
    .fill_i     (fill),
    .fill_wa_i  (pc_q[31:2]),
    .fill_data_i(word)
  );
`else
  assign hit      = 1'b0;
  assign hit_data = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst == RstnEnable) begin
      state_q    <= S_REQ;
      pc_q       <= RESET_PC;
      addr_q     <= '0;
      req_q      <= 1'b0;
      issue_q    <= '0;
      recv_q     <= '0;
      buf_q      <= '0;
      inflight_q <= 1'b0;
      pc_o_q     <= '0;
      inst_q     <= '0;
      valid_q    <= 1'b0;
    end else if (branch_i) begin
      state_q    <= S_REQ;
      pc_q       <= branch_target_i;
      addr_q     <= branch_target_i;
      req_q      <= 1'b1;
      issue_q    <= '0;
      recv_q     <= '0;
      inflight_q <= 1'b0;
      inst_q     <= '0;
      valid_q    <= 1'b0;
    end else begin
      unique case (state_q)
        S_REQ: begin
          inflight_q <= gnt;
          issue_q    <= issue_d;
          addr_q     <= pc_q + 32'(issue_d);
          req_q      <= issue_d != 3'd4;
          if (hit) begin
            pc_o_q  <= pc_q;
            inst_q  <= hit_data;
            valid_q <= 1'b1;
            req_q   <= 1'b0;
            state_q <= S_OUT;
          end else if (rv) begin
            recv_q <= recv_q + 2'd1;
            buf_q  <= {mem.mem_rdata_i, buf_q[23:8]};
            if (last) begin
              pc_o_q  <= pc_q;
              inst_q  <= word;
              valid_q <= 1'b1;
              req_q   <= 1'b0;
              state_q <= S_OUT;
            end
          end
        end
        S_OUT: begin
          if (!stall_i) begin
            state_q <= S_REQ;
            pc_q    <= pc_q + 32'd4;
            addr_q  <= pc_q + 32'd4;
            req_q   <= 1'b1;
            issue_q <= '0;
            recv_q  <= '0;
            inst_q  <= '0;
            valid_q <= 1'b0;
          end
        end
      endcase
    end
  end

  assign pc_o    = pc_o_q;
  assign inst_o  = inst_q;
  assign valid_o = valid_q;

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: byte memory model, directed scenarios and a random run
// checked every cycle against a transaction-level fetch model.
module tb_if_fetch;
  import if_fetch_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0;
  localparam int          LINES  = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst    = 1'b0;
  logic        stall  = 1'b0;
  logic        branch = 1'b0;
  logic [31:0] btgt   = '0;
  logic        gnt    = 1'b0;
  logic        rvalid = 1'b0;
  logic [7:0]  rdata  = '0;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic        valid_o;

  if_fetch_if bus();
  assign bus.mem_gnt_i    = gnt;
  assign bus.mem_rvalid_i = rvalid;
  assign bus.mem_rdata_i  = rdata;

  if_fetch #(
    .RESET_PC    (RST_PC),
    .ICACHE_LINES(LINES)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .stall_i        (stall),
    .branch_i       (branch),
    .branch_target_i(btgt),
    .mem            (bus),
    .pc_o           (pc_o),
    .inst_o         (inst_o),
    .valid_o        (valid_o)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  function automatic logic [7:0] mbyte(input logic [31:0] a);
    logic [31:0] w;
    if (a[31:2] == 30'd0) w = 32'h00500093;
    else w = ({a[31:2], 2'b00} * 32'h9E3779B1) ^ 32'h5A5A1234;
    return 8'(w >> {a[1:0], 3'b000});
  endfunction

  function automatic logic [31:0] mword(input logic [31:0] a);
    return {mbyte(a + 32'd3), mbyte(a + 32'd2),
            mbyte(a + 32'd1), mbyte(a)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)",
               name, act, exp, $time);
    end
  endtask

  // memory: what was accepted this cycle is returned next cycle
  logic        acc_q = 1'b0;
  logic [31:0] acc_a = '0;

  // fetch model
  bit          m_rst   = 1'b1;
  logic [31:0] m_pc    = RST_PC;
  logic [31:0] m_word  = '0;
  int          m_iss   = 0;
  int          m_rcv   = 0;
  bit          m_valid = 1'b0;
  bit          m_pend  = 1'b0;
  int          m_words = 0;
  bit          lv  [LINES];
  logic [29:0] lwa [LINES];
  logic [31:0] lw  [LINES];

  always @(negedge clk) begin
    bit hit;
    bit ereq;
    int idx;
    idx = int'(m_pc[7:2]);
    hit = 1'b0;
`ifdef ICACHE_EN
    hit = !m_rst && !m_valid && m_iss == 0 &&
          lv[idx] && lwa[idx] == m_pc[31:2];
`endif
    ereq = !m_rst && !m_valid && m_iss < 4 && !branch && !hit;
    if (chk_en) begin
      if (m_rst) begin
        chk("rst_req", 32'(bus.mem_req_o), 32'd0);
        chk("rst_addr", bus.mem_addr_o, 32'd0);
        chk("rst_valid", 32'(valid_o), 32'd0);
        chk("rst_pc_o", pc_o, 32'd0);
        chk("rst_inst", inst_o, 32'd0);
      end else begin
        chk("valid_o", 32'(valid_o), 32'(m_valid));
        if (m_valid) begin
          chk("pc_o", pc_o, m_pc);
          chk("inst_o", inst_o, m_word);
        end
        chk("mem_req_o", 32'(bus.mem_req_o), 32'(ereq));
        if (ereq) chk("mem_addr_o", bus.mem_addr_o, m_pc + 32'(m_iss));
      end
    end
    acc_q = bus.mem_req_o & gnt;
    acc_a = bus.mem_addr_o;
    if (!rst) begin
      m_rst = 1'b1; m_pc = RST_PC; m_iss = 0; m_rcv = 0;
      m_valid = 1'b0; m_pend = 1'b0;
      lv = '{default: 1'b0};
    end else begin
      m_rst = 1'b0;
      if (branch) begin
        m_pc = btgt; m_iss = 0; m_rcv = 0;
        m_valid = 1'b0; m_pend = 1'b0;
      end else if (m_valid) begin
        if (!stall) begin
          m_valid = 1'b0; m_pc = m_pc + 32'd4;
          m_iss = 0; m_rcv = 0; m_words++;
        end
      end else if (hit) begin
        m_valid = 1'b1; m_word = lw[idx];
      end else begin
        if (m_pend && rvalid) begin
          m_rcv++;
          if (m_rcv == 4) begin
            m_valid = 1'b1; m_word = mword(m_pc);
            lv[idx] = 1'b1; lwa[idx] = m_pc[31:2]; lw[idx] = m_word;
          end
        end
        m_pend = ereq && gnt;
        if (m_pend) m_iss++;
      end
    end
  end

  task automatic cyc(input bit g, input bit s, input bit b,
                     input logic [31:0] t, input bit r);
    @(posedge clk);
    #1;
    rvalid = acc_q;
    rdata  = mbyte(acc_a);
    gnt = g; stall = s; branch = b; btgt = t; rst = r;
    @(negedge clk);
  endtask

  // two reset edges, then one idle cycle; the next cyc is cycle 0
  task automatic rst_seq();
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    chk_en = 1'b1;
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
  endtask

  initial begin
    logic [31:0] t;

    // zero-wait fetch of 0x0
    rst_seq();
    for (int c = 0; c <= 6; c++) begin
      cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
      if (c <= 3) begin
        chk("t1_req", 32'(bus.mem_req_o), 32'd1);
        chk("t1_addr", bus.mem_addr_o, 32'(c));
      end
      if (c == 4) chk("t1_valid_c4", 32'(valid_o), 32'd0);
      if (c == 5) begin
        chk("t1_valid_c5", 32'(valid_o), 32'd1);
        chk("t1_inst", inst_o, 32'h00500093);
        chk("t1_pc", pc_o, 32'h0);
      end
      if (c == 6) begin
        chk("t1_next_req", 32'(bus.mem_req_o), 32'd1);
        chk("t1_next_addr", bus.mem_addr_o, 32'h4);
      end
    end

    // grant withheld on byte 2, then stall while presented
    rst_seq();
    for (int c = 0; c <= 13; c++) begin
      cyc(!(c >= 2 && c <= 4), (c >= 2 && c <= 11), 1'b0, 32'h0, 1'b1);
      if (c >= 2 && c <= 4) begin
        chk("t2_req_hold", 32'(bus.mem_req_o), 32'd1);
        chk("t2_addr_hold", bus.mem_addr_o, 32'h2);
      end
      if (c == 7) chk("t2_valid_c7", 32'(valid_o), 32'd0);
      if (c >= 8 && c <= 12) begin
        chk("t3_valid", 32'(valid_o), 32'd1);
        chk("t3_inst", inst_o, 32'h00500093);
        chk("t3_pc", pc_o, 32'h0);
        chk("t3_req", 32'(bus.mem_req_o), 32'd0);
      end
      if (c == 13) begin
        chk("t3_next_req", 32'(bus.mem_req_o), 32'd1);
        chk("t3_next_addr", bus.mem_addr_o, 32'h4);
      end
    end

    // branch to 0x100 while byte 1 returns
    rst_seq();
    for (int c = 0; c <= 8; c++) begin
      cyc(1'b1, 1'b0, (c == 2), 32'h100, 1'b1);
      if (c == 2) chk("t4_req_forced", 32'(bus.mem_req_o), 32'd0);
      if (c >= 3 && c <= 6) begin
        chk("t4_req", 32'(bus.mem_req_o), 32'd1);
        chk("t4_addr", bus.mem_addr_o, 32'h100 + 32'(c - 3));
      end
      if (c == 7) chk("t4_valid_c7", 32'(valid_o), 32'd0);
      if (c == 8) begin
        chk("t4_valid", 32'(valid_o), 32'd1);
        chk("t4_pc", pc_o, 32'h100);
        chk("t4_inst", inst_o, mword(32'h100));
      end
    end

    // reset while byte 2 is granted
    rst_seq();
    for (int c = 0; c <= 9; c++) begin
      cyc(1'b1, 1'b0, 1'b0, 32'h0, (c != 2));
      if (c == 3) begin
        chk("t5_req", 32'(bus.mem_req_o), 32'd0);
        chk("t5_addr", bus.mem_addr_o, 32'h0);
        chk("t5_valid", 32'(valid_o), 32'd0);
        chk("t5_pc", pc_o, 32'h0);
        chk("t5_inst", inst_o, 32'h0);
      end
      if (c == 4) begin
        chk("t5_restart_req", 32'(bus.mem_req_o), 32'd1);
        chk("t5_restart_addr", bus.mem_addr_o, RST_PC);
      end
      if (c == 9) begin
        chk("t5_valid_c9", 32'(valid_o), 32'd1);
        chk("t5_inst_c9", inst_o, 32'h00500093);
      end
    end

    // loop 0x0 -> 0x4 -> branch back to 0x0
    rst_seq();
    for (int c = 0; c <= 13; c++) begin
      cyc(1'b1, 1'b0, (c == 11), 32'h0, 1'b1);
      if (c == 11) chk("t6_valid_4", 32'(valid_o), 32'd1);
`ifdef ICACHE_EN
      if (c == 12) chk("t6_hit_noreq", 32'(bus.mem_req_o), 32'd0);
      if (c == 13) begin
        chk("t6_hit_valid", 32'(valid_o), 32'd1);
        chk("t6_hit_pc", pc_o, 32'h0);
        chk("t6_hit_inst", inst_o, 32'h00500093);
      end
`else
      if (c == 12) begin
        chk("t6_refetch_req", 32'(bus.mem_req_o), 32'd1);
        chk("t6_refetch_addr", bus.mem_addr_o, 32'h0);
      end
      if (c == 13) chk("t6_refetch_valid", 32'(valid_o), 32'd0);
`endif
    end

    // random traffic
    rst_seq();
    m_words = 0;
    for (int n = 0; n < 3000; n++) begin
      case ($urandom_range(0, 9))
        0: t = 32'hFFFF_FFFC;
        1: t = 32'($urandom_range(0, 63));
        default: t = 32'($urandom_range(0, 15)) << 2;
      endcase
      cyc($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 4,
          $urandom_range(0, 24) == 0, t, $urandom_range(0, 299) != 0);
    end
    chk("rand_progress", 32'(m_words > 20), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
